// File: rtl/column_feeder.sv
`timescale 1ns/1ps
// column_feeder: LFSR-driven letter source and fall-step timer for one falling-letter column.
// Define FEEDER_SPEEDUP_EN to shorten the step period as levels rise; otherwise the period stays at TICK_BASE.
module column_feeder #(
    parameter int unsigned TICK_BASE   = 25_000_000,
    parameter int unsigned TICK_STEP   = 1_000_000,
    parameter int unsigned LEVEL_EVERY = 4,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset_signal,
    input  logic       enable,
    input  logic       req,
    output logic [7:0] letter,
    output logic       letter_valid,
    output logic       step,
    output logic [3:0] level,
    output logic [7:0] solved_count
);
    localparam logic [15:0] SEED_FIX  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [24:0] BASE_25   = 25'(TICK_BASE);
    localparam logic [24:0] STEP_25   = 25'(TICK_STEP);

    if (TICK_BASE <= 15 * TICK_STEP || LEVEL_EVERY < 1) begin : g_param_check
        $error("column_feeder: TICK_BASE must exceed 15*TICK_STEP and LEVEL_EVERY must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, SPAWN, RUN, HOLD} state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  letter_q, letter_d;
    logic        valid_q, valid_d;
    logic        step_q, step_d;
    logic [24:0] tick_q, tick_d;
    logic [7:0]  solved_q, solved_d;
    logic [3:0]  level_cur;
    logic [24:0] period_m1;
    logic [7:0]  pick_letter;

`ifdef FEEDER_SPEEDUP_EN
    localparam int unsigned          DIV_W    = (LEVEL_EVERY > 1) ? $clog2(LEVEL_EVERY) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(LEVEL_EVERY - 1);

    logic [3:0]       level_q, level_d;
    logic [DIV_W-1:0] div_q, div_d;

    assign level_cur = level_q;
`else
    assign level_cur = 4'd0;
`endif

    // The LFSR is never all-zero, so at least one of its bytes is nonzero.
    assign pick_letter = (lfsr_q[7:0] != 8'h00) ? lfsr_q[7:0] : lfsr_q[15:8];
    assign period_m1   = BASE_25 - (25'(level_cur) * STEP_25) - 25'd1;

    always_comb begin
        state_d  = state_q;
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
        letter_d = letter_q;
        valid_d  = valid_q;
        step_d   = 1'b0;
        tick_d   = tick_q;
        solved_d = solved_q;
`ifdef FEEDER_SPEEDUP_EN
        level_d  = level_q;
        div_d    = div_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = SPAWN;
            end
            SPAWN: begin
                letter_d = pick_letter;
                valid_d  = 1'b1;
                tick_d   = 25'd0;
                state_d  = RUN;
            end
            RUN: begin
                // Priority: hold beats a solve, and a solve beats the step terminal count.
                if (!enable) begin
                    state_d = HOLD;
                end else if (req) begin
                    state_d = SPAWN;
                    valid_d = 1'b0;
                    tick_d  = 25'd0;
                    if (solved_q != 8'hFF) solved_d = solved_q + 8'd1;
`ifdef FEEDER_SPEEDUP_EN
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        if (level_q != 4'hF) level_d = level_q + 4'd1;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
`endif
                end else if (tick_q == period_m1) begin
                    step_d = 1'b1;
                    tick_d = 25'd0;
                end else begin
                    tick_d = tick_q + 25'd1;
                end
            end
            HOLD: begin
                if (enable) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED_FIX;
            letter_q <= 8'h00;
            valid_q  <= 1'b0;
            step_q   <= 1'b0;
            tick_q   <= 25'd0;
            solved_q <= 8'h00;
`ifdef FEEDER_SPEEDUP_EN
            level_q  <= 4'd0;
            div_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            letter_q <= letter_d;
            valid_q  <= valid_d;
            step_q   <= step_d;
            tick_q   <= tick_d;
            solved_q <= solved_d;
`ifdef FEEDER_SPEEDUP_EN
            level_q  <= level_d;
            div_q    <= div_d;
`endif
        end
    end

    assign letter       = letter_q;
    assign letter_valid = valid_q;
    assign step         = step_q;
    assign level        = level_cur;
    assign solved_count = solved_q;

endmodule

// File: tb/tb_column_feeder.sv
`timescale 1ns/1ps
// tb_column_feeder: randomized scenario bench for column_feeder against a cycle-level behavioural model.
module tb_column_feeder;
    localparam int unsigned TICK_BASE   = 20;
    localparam int unsigned TICK_STEP   = 1;
    localparam int unsigned LEVEL_EVERY = 2;
    localparam logic [15:0] SEED        = 16'hACE1;
`ifdef FEEDER_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic       clock        = 1'b0;
    logic       reset_signal = 1'b1;
    logic       enable       = 1'b0;
    logic       req          = 1'b0;
    logic [7:0] letter;
    logic       letter_valid;
    logic       step;
    logic [3:0] level;
    logic [7:0] solved_count;

    column_feeder #(
        .TICK_BASE  (TICK_BASE),
        .TICK_STEP  (TICK_STEP),
        .LEVEL_EVERY(LEVEL_EVERY),
        .SEED       (SEED)
    ) dut (
        .clock       (clock),
        .reset_signal(reset_signal),
        .enable      (enable),
        .req         (req),
        .letter      (letter),
        .letter_valid(letter_valid),
        .step        (step),
        .level       (level),
        .solved_count(solved_count)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: mode 0 waiting, 1 fetching a letter, 2 falling, 3 paused.
    int          m_mode    = 0;
    logic [15:0] m_lfsr    = SEED;
    logic [7:0]  m_letter  = 8'h00;
    bit          m_valid   = 1'b0;
    bit          m_step    = 1'b0;
    int          m_level   = 0;
    int          m_solved  = 0;
    int          m_div     = 0;
    int          m_elapsed = 0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [7:0] pick_of(input logic [15:0] v);
        return (v[7:0] != 8'h00) ? v[7:0] : v[15:8];
    endfunction

    function automatic int period_of(input int lvl);
        return TICK_BASE - lvl * TICK_STEP;
    endfunction

    function automatic logic [21:0] obs_vec();
        return {letter, letter_valid, step, level, solved_count};
    endfunction

    function automatic logic [21:0] exp_vec();
        return {m_letter, m_valid, m_step, 4'(m_level), 8'(m_solved)};
    endfunction

    task automatic model_update();
        bit step_now;
        step_now = 1'b0;
        if (reset_signal) begin
            m_mode = 0; m_lfsr = SEED; m_letter = 8'h00; m_valid = 1'b0; m_step = 1'b0;
            m_level = 0; m_solved = 0; m_div = 0; m_elapsed = 0;
            return;
        end
        case (m_mode)
            0: if (enable) m_mode = 1;
            1: begin
                m_letter = pick_of(m_lfsr); m_valid = 1'b1; m_elapsed = 0; m_mode = 2;
            end
            2: begin
                if (!enable) begin
                    m_mode = 3;
                end else if (req) begin
                    m_valid = 1'b0; m_elapsed = 0; m_mode = 1;
                    if (m_solved < 255) m_solved++;
                    if (SPEEDUP) begin
                        m_div++;
                        if (m_div == LEVEL_EVERY) begin
                            m_div = 0;
                            if (m_level < 15) m_level++;
                        end
                    end
                end else if (m_elapsed == period_of(m_level) - 1) begin
                    step_now = 1'b1; m_elapsed = 0;
                end else begin
                    m_elapsed++;
                end
            end
            3: if (enable) m_mode = 2;
            default: m_mode = 0;
        endcase
        m_step = step_now;
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic tick();
        @(posedge clock);
        model_update();
        #1;
        cyc++;
    endtask

    task automatic wait_for_valid(input int limit, output bit ok);
        int n;
        n = 0;
        while (letter_valid !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        ok = (letter_valid === 1'b1);
    endtask

    task automatic wait_for_step(input int limit, output int waited, output bit ok);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (step !== 1'b1 && waited < limit);
        ok = (step === 1'b1);
    endtask

    task automatic test_reset();
        reset_signal = 1'b1; enable = 1'b1; req = 1'b1;
        tick(); tick();
        n_cmp++;
        if (obs_vec() !== 22'd0) begin
            n_fail++; $display("[TB] FAIL reset_values: got %h expected 000000", obs_vec());
        end
        reset_signal = 1'b0; enable = 1'b0; req = 1'b0;
        repeat (3) begin
            tick();
            n_cmp++;
            if (letter_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
                n_fail++; $display("[TB] FAIL idle_stays: got %h expected %h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_enable_start();
        int steps[$];
        int want[3] = '{22, 42, 62};
        reset_signal = 1'b1; tick();
        reset_signal = 1'b0; enable = 1'b1; cyc = 0;
        for (int k = 1; k <= 65; k++) begin
            tick();
            if (step === 1'b1) steps.push_back(cyc);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("[TB] FAIL start_model cyc=%0d: got %h expected %h", cyc, obs_vec(), exp_vec());
            end
            if (k == 1) begin
                n_cmp++;
                if (letter_valid !== 1'b0) begin
                    n_fail++; $display("[TB] FAIL spawn_invalid: got %0b expected 0", letter_valid);
                end
            end
            if (k == 2) begin
                n_cmp++;
                if (letter_valid !== 1'b1 || letter !== pick_of(lfsr_next(SEED))) begin
                    n_fail++; $display("[TB] FAIL first_letter: got %b/%h expected 1/%h", letter_valid, letter, pick_of(lfsr_next(SEED)));
                end
            end
        end
        n_cmp++;
        if (steps.size() != 3) begin
            n_fail++; $display("[TB] FAIL step_count: got %0d expected 3", steps.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (steps[i] != want[i]) begin
                    n_fail++; $display("[TB] FAIL step_cycle[%0d]: got %0d expected %0d", i, steps[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_level_speedup();
        bit ok;
        int w;
        int exp_level = SPEEDUP ? 2 : 0;
        for (int r = 0; r < 4; r++) begin
            wait_for_valid(100, ok);
            n_cmp++;
            if (!ok) begin
                n_fail++; $display("[TB] FAIL valid_timeout r=%0d: got 0 expected 1", r);
            end
            repeat (5) tick();
            req = 1'b1; tick(); req = 1'b0;
            n_cmp++;
            if (letter_valid !== 1'b0) begin
                n_fail++; $display("[TB] FAIL req_drops_valid r=%0d: got %0b expected 0", r, letter_valid);
            end
            tick();
            n_cmp++;
            if (letter_valid !== 1'b1 || letter === 8'h00 || obs_vec() !== exp_vec()) begin
                n_fail++; $display("[TB] FAIL req_revalid r=%0d: got %h expected %h", r, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (solved_count !== 8'd4 || level !== 4'(exp_level)) begin
            n_fail++; $display("[TB] FAIL level_after_4: got %0d/%0d expected 4/%0d", solved_count, level, exp_level);
        end
        wait_for_step(100, w, ok);
        wait_for_step(100, w, ok);
        n_cmp++;
        if (!ok || w != period_of(exp_level)) begin
            n_fail++; $display("[TB] FAIL step_spacing: got %0d expected %0d", w, period_of(exp_level));
        end
    endtask

    task automatic test_req_on_step();
        bit ok;
        int w;
        reset_signal = 1'b1; enable = 1'b0; tick();
        reset_signal = 1'b0; enable = 1'b1;
        wait_for_step(100, w, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++; $display("[TB] FAIL step_timeout: got 0 expected 1");
        end
        repeat (TICK_BASE - 1) tick();
        req = 1'b1; tick(); req = 1'b0;
        n_cmp++;
        if (step !== 1'b0 || letter_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("[TB] FAIL req_beats_step: got step=%0b valid=%0b expected 0/0", step, letter_valid);
        end
        tick();
        n_cmp++;
        if (letter_valid !== 1'b1) begin
            n_fail++; $display("[TB] FAIL revalid_after_tc: got %0b expected 1", letter_valid);
        end
        wait_for_step(100, w, ok);
        n_cmp++;
        if (!ok || w != TICK_BASE) begin
            n_fail++; $display("[TB] FAIL step_after_tc_req: got %0d expected %0d", w, TICK_BASE);
        end
    endtask

    task automatic test_hold();
        bit ok;
        int w;
        logic [7:0] let0;
        logic [7:0] sol0;
        repeat (7) tick();
        let0 = m_letter;
        sol0 = 8'(m_solved);
        enable = 1'b0;
        for (int i = 0; i < 50; i++) begin
            req = (i % 10 == 0) || (i % 10 == 5);
            tick();
            n_cmp++;
            if (step !== 1'b0 || letter !== let0 || solved_count !== sol0 || letter_valid !== 1'b1) begin
                n_fail++; $display("[TB] FAIL hold_frozen i=%0d: got %0b/%h/%0d expected 0/%h/%0d", i, step, letter, solved_count, let0, sol0);
            end
        end
        req = 1'b0; enable = 1'b1;
        wait_for_step(100, w, ok);
        n_cmp++;
        if (!ok || w != 1 + (TICK_BASE - 7)) begin
            n_fail++; $display("[TB] FAIL hold_resume: got %0d expected %0d", w, 1 + (TICK_BASE - 7));
        end
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("[TB] FAIL hold_model: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_saturation();
        bit ok;
        int w;
        int exp_level = SPEEDUP ? 15 : 0;
        for (int r = 0; r < 40; r++) begin
            wait_for_valid(50, ok);
            repeat ($urandom_range(0, 3)) tick();
            n_cmp++;
            if (!ok || letter === 8'h00 || obs_vec() !== exp_vec()) begin
                n_fail++; $display("[TB] FAIL spawn_letter r=%0d: got %h expected %h", r, obs_vec(), exp_vec());
            end
            req = 1'b1; tick(); req = 1'b0;
        end
        wait_for_valid(50, ok);
        n_cmp++;
        if (level !== 4'(exp_level) || solved_count !== 8'd41) begin
            n_fail++; $display("[TB] FAIL level_saturate: got %0d/%0d expected %0d/41", level, solved_count, exp_level);
        end
        wait_for_step(100, w, ok);
        wait_for_step(100, w, ok);
        n_cmp++;
        if (!ok || w != period_of(exp_level)) begin
            n_fail++; $display("[TB] FAIL fast_spacing: got %0d expected %0d", w, period_of(exp_level));
        end
        req = 1'b1;
        repeat (650) begin
            tick();
            n_cmp++;
            if ((letter_valid === 1'b1 && letter === 8'h00) || obs_vec() !== exp_vec()) begin
                n_fail++; $display("[TB] FAIL held_req_model: got %h expected %h", obs_vec(), exp_vec());
            end
        end
        req = 1'b0;
        n_cmp++;
        if (solved_count !== 8'd255) begin
            n_fail++; $display("[TB] FAIL solved_saturate: got %0d expected 255", solved_count);
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int exp_level = SPEEDUP ? 3 : 0;
        reset_signal = 1'b1; enable = 1'b0; tick();
        reset_signal = 1'b0; enable = 1'b1;
        for (int r = 0; r < 6; r++) begin
            wait_for_valid(50, ok);
            repeat ($urandom_range(1, 4)) tick();
            req = 1'b1; tick(); req = 1'b0;
        end
        wait_for_valid(50, ok);
        repeat (3) tick();
        n_cmp++;
        if (level !== 4'(exp_level) || letter_valid !== 1'b1) begin
            n_fail++; $display("[TB] FAIL level_before_reset: got %0d expected %0d", level, exp_level);
        end
        reset_signal = 1'b1; tick();
        n_cmp++;
        if (obs_vec() !== 22'd0) begin
            n_fail++; $display("[TB] FAIL mid_reset_values: got %h expected 000000", obs_vec());
        end
        reset_signal = 1'b0; enable = 1'b1;
        tick(); tick();
        n_cmp++;
        if (letter_valid !== 1'b1 || letter !== pick_of(lfsr_next(SEED))) begin
            n_fail++; $display("[TB] FAIL replay_letter: got %b/%h expected 1/%h", letter_valid, letter, pick_of(lfsr_next(SEED)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_enable_start();
        test_level_speedup();
        test_req_on_step();
        test_hold();
        test_saturation();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
